// File: rtl/glyph_rom_arbiter_pkg.sv
// Shared constants, FSM encoding and requester indices for the glyph ROM arbiter.
package glyph_rom_arbiter_pkg;

  localparam int N_REQ   = 4;
  localparam int ROWS    = 16;
  localparam int ROW_W   = 16;
  localparam int GLYPH_W = 4;
  localparam int ROW_IW  = 4;

  localparam logic [ROW_IW-1:0] LAST_ROW = ROW_IW'(ROWS - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  localparam logic [1:0] P_OPA     = 2'd0;
  localparam logic [1:0] P_OPB     = 2'd1;
  localparam logic [1:0] P_DISP_HI = 2'd2;
  localparam logic [1:0] P_DISP_LO = 2'd3;

  function automatic logic [N_REQ-1:0] port_onehot(input logic [1:0] p);
    return N_REQ'(1) << p;
  endfunction

endpackage

// File: rtl/glyph_rom.sv
// 256x16 synchronous-read glyph ROM: address {glyph, row}, data one cycle after the address.
module glyph_rom
  import glyph_rom_arbiter_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [7:0]       i_addr,
  output logic [ROW_W-1:0] o_rdata
);

  logic [GLYPH_W-1:0] w_g;
  logic [ROW_IW-1:0]  w_r;
  logic [ROW_W-1:0]   w_row_bits;
  logic [ROW_W-1:0]   r_data;

  assign w_g = i_addr[7:4];
  assign w_r = i_addr[3:0];

  // Pattern chosen so every row of every glyph is distinct and easy to recognise on a trace.
  assign w_row_bits = {w_g, w_r, w_g ^ w_r, ~w_g};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data <= '0;
    end else if (i_en) begin
      r_data <= w_row_bits;
    end
  end

  assign o_rdata = r_data;

endmodule

// File: rtl/glyph_rom_arbiter.sv
// Four-port glyph burst arbiter: grants one requester at a time a 16-row ROM burst.
//   state    | meaning
//   ST_IDLE  | no burst in flight; every cycle is a decision point
//   ST_BURST | issuing rows 0..15; the row-15 cycle is a decision point
module glyph_rom_arbiter
  import glyph_rom_arbiter_pkg::*;
#(
  parameter int PRIO_DISP = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [15:0]        glyph,
  output logic [N_REQ-1:0]   ack,
  output logic               busy,
  output logic [ROW_W-1:0]   rdata,
  output logic               rvalid,
  output logic [1:0]         rid,
  output logic [ROW_IW-1:0]  rrow,
  output logic               rlast
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ROW_IW-1:0]  r_row;
  logic [1:0]         r_owner;
  logic [GLYPH_W-1:0] r_glyph;
  logic [N_REQ-1:0]   r_ack;
  logic               r_ptr_disp;
  logic               r_ptr_op;
  logic [1:0]         r_ptr_rr;
  logic               r_rvalid;
  logic [1:0]         r_rid;
  logic [ROW_IW-1:0]  r_rrow;
  logic               r_rlast;

  logic               w_issue;
  logic               w_decide;
  logic               w_grant;
  logic [1:0]         w_win;
  logic [1:0]         w_idx;

  assign w_issue  = (r_state == ST_BURST);
  assign w_decide = (r_state == ST_IDLE) || (r_row == LAST_ROW);

  always_comb begin
    w_win = P_OPA;
    w_idx = 2'd0;
    if (PRIO_DISP != 0) begin
      if (req[P_DISP_HI] || req[P_DISP_LO]) begin
        w_win = (req[P_DISP_HI] && (!r_ptr_disp || !req[P_DISP_LO])) ? P_DISP_HI : P_DISP_LO;
      end else begin
        w_win = (req[P_OPA] && (!r_ptr_op || !req[P_OPB])) ? P_OPA : P_OPB;
      end
    end else begin
      // Scan from the farthest offset down so the nearest requester at/after the pointer wins.
      for (int i = N_REQ - 1; i >= 0; i--) begin
        w_idx = r_ptr_rr + 2'(i);
        if (req[w_idx]) w_win = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    if (w_decide) begin
      if (|req) begin
        w_state_nxt = ST_BURST;
        w_grant     = 1'b1;
      end else begin
        w_state_nxt = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_row      <= '0;
      r_owner    <= '0;
      r_glyph    <= '0;
      r_ack      <= '0;
      r_ptr_disp <= 1'b0;
      r_ptr_op   <= 1'b0;
      r_ptr_rr   <= 2'd0;
      r_rvalid   <= 1'b0;
      r_rid      <= '0;
      r_rrow     <= '0;
      r_rlast    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ack    <= w_grant ? port_onehot(w_win) : '0;
      r_rvalid <= w_issue;
      r_rlast  <= w_issue && (r_row == LAST_ROW);
      if (w_issue) begin
        r_rid  <= r_owner;
        r_rrow <= r_row;
      end
      if (w_grant) begin
        r_owner <= w_win;
        r_glyph <= glyph[{w_win, 2'b00} +: GLYPH_W];
        r_row   <= '0;
        if (PRIO_DISP != 0) begin
          if (w_win[1]) r_ptr_disp <= ~w_win[0];
          else          r_ptr_op   <= ~w_win[0];
        end else begin
          r_ptr_rr <= w_win + 2'd1;
        end
      end else if (w_issue) begin
        r_row <= r_row + 1'b1;
      end
    end
  end

  glyph_rom u_glyph_rom (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_en    (w_issue),
    .i_addr  ({r_glyph, r_row}),
    .o_rdata (rdata)
  );

  assign ack    = r_ack;
  assign busy   = (r_state == ST_BURST);
  assign rvalid = r_rvalid;
  assign rid    = r_rid;
  assign rrow   = r_rrow;
  assign rlast  = r_rlast;

endmodule
